store_access_ctrl: RTL and testbench

- Sequences the single-port data store (ring buffer RAM) and shares it between one write requester and one read requester.
- Keeps write/read pointers and occupancy, and arbitrates one RAM access per cycle with alternating priority.
- Drives registered RAM address, write-enable and output-enable strobes, plus a read-data-valid strobe.
- Sits between the input sampler, the data store and the output formatter.

---
 rtl/store_access_ctrl_pkg.sv | 25 ++
 rtl/arb2_rr.sv | 45 ++++
 rtl/store_access_ctrl.sv | 86 ++++++++
 tb/tb_store_access_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_access_ctrl_pkg.sv
// Shared definitions for the data-store access controller: default sizing,
// arbitration state encodings and a constant clog2 helper.
package store_access_ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic {
    ARB_WR_PRI = 1'b0,
    ARB_RD_PRI = 1'b1
  } arb_state_t;

  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb2_rr.sv
// Two-way alternating-priority arbiter; grant[0] = writer, grant[1] = reader.
// Grant is combinational and forced low while reset is asserted.
//
// state      | meaning
// ARB_WR_PRI | writer wins a tie; any grant moves to ARB_RD_PRI
// ARB_RD_PRI | reader wins a tie; any grant moves to ARB_WR_PRI
module arb2_rr
  import store_access_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       elig_wr,
  input  logic       elig_rd,
  output logic [1:0] grant
);

  arb_state_t state, state_next;

  always_ff @(posedge clock) begin
    if (!reset) state <= ARB_WR_PRI;
    else        state <= state_next;
  end

  always_comb begin
    grant      = 2'b00;
    state_next = state;
    if (reset) begin
      case (state)
        ARB_WR_PRI: begin
          if (elig_wr)      grant = 2'b01;
          else if (elig_rd) grant = 2'b10;
        end
        ARB_RD_PRI: begin
          if (elig_rd)      grant = 2'b10;
          else if (elig_wr) grant = 2'b01;
        end
        default: grant = 2'b00;
      endcase
      // Any grant hands priority to the other side, even an uncontested one.
      if (grant != 2'b00)
        state_next = (state == ARB_WR_PRI) ? ARB_RD_PRI : ARB_WR_PRI;
    end
  end

endmodule

// File: rtl/store_access_ctrl.sv
// Ring-buffer access sequencer for the single-port data store: pointers,
// occupancy, registered RAM strobes and the read-data-valid pipeline.
module store_access_ctrl
  import store_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_req,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [ADDR_W-1:0] ram_adrs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = clog2_f(DEPTH) + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [RD_LAT-1:0] oe_pipe;
  logic [1:0]        grant;
  logic              elig_wr;
  logic              elig_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign elig_wr = wr_req && !full;
  assign elig_rd = rd_req && !empty;

  arb2_rr u_arb (
    .clock   (clock),
    .reset   (reset),
    .elig_wr (elig_wr),
    .elig_rd (elig_rd),
    .grant   (grant)
  );

  assign wr_ack   = grant[0];
  assign rd_ack   = grant[1];
  assign count    = count_q;
  assign rd_valid = oe_pipe[RD_LAT-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      ram_adrs <= '0;
      ram_we   <= 1'b0;
      ram_oe   <= 1'b0;
    end else begin
      ram_we <= wr_ack;
      ram_oe <= rd_ack;
      if (wr_ack) begin
        ram_adrs <= wr_ptr;
        wr_ptr   <= wr_ptr + ADDR_W'(1);
        count_q  <= count_q + CNT_W'(1);
      end else if (rd_ack) begin
        ram_adrs <= rd_ptr;
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        count_q  <= count_q - CNT_W'(1);
      end
    end
  end

  // Clearing the pipe on reset drops any read already issued to the RAM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      oe_pipe <= '0;
    end else begin
      oe_pipe[0] <= ram_oe;
      for (int i = 1; i < RD_LAT; i++) oe_pipe[i] <= oe_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_store_access_ctrl.sv
// Self-checking bench for store_access_ctrl: reference model plus a queue of
// expected RAM operations and read-valid times, checked as the DUT emits them.
module tb_store_access_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DUT 1: RD_LAT=1, main scenarios
  logic          reset = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic          wr_ack, rd_ack, ram_we, ram_oe, rd_valid, full, empty;
  logic [AW-1:0] ram_adrs;
  logic [AW:0]   count;

  // DUT 2: RD_LAT=2, reset-during-read scenario
  logic          reset2 = 1'b0, wr_req2 = 1'b0, rd_req2 = 1'b0;
  logic          wr_ack2, rd_ack2, ram_we2, ram_oe2, rd_valid2, full2, empty2;
  logic [AW-1:0] ram_adrs2;
  logic [AW:0]   count2;

  store_access_ctrl #(.ADDR_W(AW), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset), .wr_req(wr_req), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .ram_adrs(ram_adrs), .ram_we(ram_we),
    .ram_oe(ram_oe), .rd_valid(rd_valid), .count(count), .full(full), .empty(empty));

  store_access_ctrl #(.ADDR_W(AW), .RD_LAT(2)) dut2 (
    .clock(clock), .reset(reset2), .wr_req(wr_req2), .wr_ack(wr_ack2),
    .rd_req(rd_req2), .rd_ack(rd_ack2), .ram_adrs(ram_adrs2), .ram_we(ram_we2),
    .ram_oe(ram_oe2), .rd_valid(rd_valid2), .count(count2), .full(full2), .empty(empty2));

  typedef struct {
    logic          we;
    logic [AW-1:0] adrs;
    int            due;
  } op_t;

  op_t ops_q[$];
  int  rv_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;

  logic [AW-1:0] m_wr_ptr, m_rd_ptr;
  int            m_count;
  logic          m_pri;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: every cycle either the expected op appears or strobes are idle.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (ops_q.size() > 0 && ops_q[0].due == cyc) begin
        op_t op;
        op = ops_q.pop_front();
        if (ram_we !== op.we || ram_oe !== !op.we || ram_adrs !== op.adrs) begin
          failures++;
          $display("FAIL ram_op cyc=%0d got we=%b oe=%b adrs=%0d want we=%b oe=%b adrs=%0d",
                   cyc, ram_we, ram_oe, ram_adrs, op.we, !op.we, op.adrs);
        end
      end else if (ram_we !== 1'b0 || ram_oe !== 1'b0) begin
        failures++;
        $display("FAIL ram_idle cyc=%0d got we=%b oe=%b want 0 0", cyc, ram_we, ram_oe);
      end
      checks++;
      if (rv_q.size() > 0 && rv_q[0] == cyc) begin
        void'(rv_q.pop_front());
        if (rd_valid !== 1'b1) begin
          failures++;
          $display("FAIL rd_valid cyc=%0d got %b want 1", cyc, rd_valid);
        end
      end else if (rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL rd_valid_idle cyc=%0d got %b want 0", cyc, rd_valid);
      end
    end
  end

  // Drive one cycle on DUT 1; return model-expected and observed acks.
  task automatic step(input logic w, input logic r,
                      output logic ew, output logic er, output logic ow, output logic orr);
    logic elw, elr;
    wr_req = w;
    rd_req = r;
    @(negedge clock);
    elw = w && (m_count != DEPTH);
    elr = r && (m_count != 0);
    if (!m_pri) begin ew = elw; er = elr && !elw; end
    else        begin er = elr; ew = elw && !elr; end
    ow  = wr_ack;
    orr = rd_ack;
    if (ew) begin
      ops_q.push_back('{1'b1, m_wr_ptr, cyc + 1});
      m_wr_ptr = m_wr_ptr + 1'b1;
      m_count++;
    end
    if (er) begin
      ops_q.push_back('{1'b0, m_rd_ptr, cyc + 1});
      rv_q.push_back(cyc + 2);
      m_rd_ptr = m_rd_ptr + 1'b1;
      m_count--;
    end
    if (ew || er) m_pri = !m_pri;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic ew, er, ow, orr;
    mon_en = 1'b0;
    reset = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    @(negedge clock);
    checks++;
    if (wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
      failures++; $display("FAIL ack_in_reset got %b%b want 00", wr_ack, rd_ack);
    end
    @(posedge clock); @(posedge clock); #1;
    wr_req = 1'b0; rd_req = 1'b0; reset = 1'b1;
    ops_q.delete(); rv_q.delete();
    m_wr_ptr = '0; m_rd_ptr = '0; m_count = 0; m_pri = 1'b0;
    checks++;
    if (count !== 0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL reset_flags got count=%0d empty=%b full=%b want 0 1 0", count, empty, full);
    end
    checks++;
    if (ram_we !== 1'b0 || ram_oe !== 1'b0 || rd_valid !== 1'b0 || ram_adrs !== 0) begin
      failures++;
      $display("FAIL reset_strobes got we=%b oe=%b rv=%b adrs=%0d want 0 0 0 0", ram_we, ram_oe, rd_valid, ram_adrs);
    end
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, ew, er, ow, orr);
      checks++;
      if (ow !== 1'b0 || orr !== 1'b0) begin
        failures++; $display("FAIL idle_ack got %b%b want 00", ow, orr);
      end
    end
  endtask

  task automatic test_fill();
    logic ew, er, ow, orr;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, ew, er, ow, orr);
      checks++;
      if (ow !== 1'b1 || ew !== 1'b1) begin
        failures++; $display("FAIL fill_ack i=%0d got %b want 1", i, ow);
      end
    end
    checks++;
    if (full !== 1'b1 || count !== 4 || empty !== 1'b0) begin
      failures++; $display("FAIL fill_full got full=%b count=%0d want 1 4", full, count);
    end
    step(1'b1, 1'b0, ew, er, ow, orr);
    checks++;
    if (ow !== 1'b0) begin
      failures++; $display("FAIL write_when_full got wr_ack=%b want 0", ow);
    end
  endtask

  task automatic test_drain();
    logic ew, er, ow, orr;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, ew, er, ow, orr);
      checks++;
      if (orr !== 1'b1) begin
        failures++; $display("FAIL drain_ack i=%0d got %b want 1", i, orr);
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 0) begin
      failures++; $display("FAIL drain_empty got empty=%b count=%0d want 1 0", empty, count);
    end
    step(1'b0, 1'b1, ew, er, ow, orr);
    checks++;
    if (orr !== 1'b0) begin
      failures++; $display("FAIL read_when_empty got rd_ack=%b want 0", orr);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, ew, er, ow, orr);
  endtask

  task automatic test_empty_write();
    logic ew, er, ow, orr;
    step(1'b1, 1'b1, ew, er, ow, orr);
    checks++;
    if (ow !== 1'b1 || orr !== 1'b0) begin
      failures++; $display("FAIL empty_write got wr=%b rd=%b want 1 0", ow, orr);
    end
    step(1'b0, 1'b1, ew, er, ow, orr);
    checks++;
    if (orr !== 1'b1 || count !== 0) begin
      failures++; $display("FAIL read_after_write got rd=%b count=%0d want 1 0", orr, count);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, ew, er, ow, orr);
  endtask

  task automatic test_alternate();
    logic ew, er, ow, orr;
    step(1'b1, 1'b0, ew, er, ow, orr);
    step(1'b1, 1'b0, ew, er, ow, orr);
    checks++;
    if (count !== 2) begin
      failures++; $display("FAIL alt_start got count=%0d want 2", count);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, ew, er, ow, orr);
      checks++;
      if (ow !== ((i % 2) == 0) || orr !== ((i % 2) == 1) || ow !== ew || orr !== er) begin
        failures++; $display("FAIL alt_grant i=%0d got wr=%b rd=%b want wr=%b", i, ow, orr, (i % 2) == 0);
      end
      checks++;
      if (count < 2 || count > 3) begin
        failures++; $display("FAIL alt_count i=%0d got %0d want 2..3", i, count);
      end
    end
    step(1'b0, 1'b1, ew, er, ow, orr);
    step(1'b0, 1'b1, ew, er, ow, orr);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, ew, er, ow, orr);
    checks++;
    if (count !== 0 || empty !== 1'b1) begin
      failures++; $display("FAIL alt_end got count=%0d want 0", count);
    end
  endtask

  task automatic test_wrap();
    logic ew, er, ow, orr;
    int nw, nr, iter;
    nw = 0; nr = 0; iter = 0;
    while ((nw < 10 || nr < 10) && iter < 300) begin
      step((nw < 10) && ($urandom_range(0, 1) == 1), (nr < 10) && ($urandom_range(0, 2) != 0),
           ew, er, ow, orr);
      checks++;
      if (ow !== ew || orr !== er) begin
        failures++; $display("FAIL wrap_ack got wr=%b rd=%b want wr=%b rd=%b", ow, orr, ew, er);
      end
      if (ew) nw++;
      if (er) nr++;
      iter++;
    end
    checks++;
    if (nw != 10 || nr != 10) begin
      failures++; $display("FAIL wrap_budget got writes=%0d reads=%0d want 10 10", nw, nr);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, ew, er, ow, orr);
    checks++;
    if (count !== 0 || empty !== 1'b1) begin
      failures++; $display("FAIL wrap_end got count=%0d empty=%b want 0 1", count, empty);
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clock); #1;
    reset2 = 1'b1;
    wr_req2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (wr_ack2 !== 1'b1) begin
        failures++; $display("FAIL mf_write i=%0d got %b want 1", i, wr_ack2);
      end
      @(posedge clock); #1;
    end
    wr_req2 = 1'b0; rd_req2 = 1'b1;
    @(negedge clock);
    checks++;
    if (rd_ack2 !== 1'b1) begin
      failures++; $display("FAIL mf_read got rd_ack=%b want 1", rd_ack2);
    end
    @(posedge clock); #1;
    rd_req2 = 1'b0;
    checks++;
    if (ram_oe2 !== 1'b1) begin
      failures++; $display("FAIL mf_oe got %b want 1", ram_oe2);
    end
    reset2 = 1'b0;
    @(posedge clock); #1;
    reset2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if (rd_valid2 !== 1'b0) begin
        failures++; $display("FAIL mf_rd_valid i=%0d got %b want 0", i, rd_valid2);
      end
    end
    checks++;
    if (count2 !== 0 || empty2 !== 1'b1) begin
      failures++; $display("FAIL mf_count got count=%0d empty=%b want 0 1", count2, empty2);
    end
    @(posedge clock); #1;
    wr_req2 = 1'b1;
    @(negedge clock);
    checks++;
    if (wr_ack2 !== 1'b1) begin
      failures++; $display("FAIL mf_rewrite got wr_ack=%b want 1", wr_ack2);
    end
    @(posedge clock); #1;
    wr_req2 = 1'b0;
    checks++;
    if (ram_we2 !== 1'b1 || ram_adrs2 !== 0) begin
      failures++; $display("FAIL mf_addr got we=%b adrs=%0d want 1 0", ram_we2, ram_adrs2);
    end
  endtask

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_fill();
    test_drain();
    test_empty_write();
    test_alternate();
    test_wrap();
    mon_en = 1'b0;
    checks++;
    if (ops_q.size() != 0 || rv_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got ops=%0d rv=%0d want 0 0", ops_q.size(), rv_q.size());
    end
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
